data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the pipeline MEM stage (LOAD, STR, STR_ONE) and the camera pixel writer.
- The camera writer streams frame words over a valid/ready handshake.
- Drives the memory port and returns read data to the MEM stage.
- Raises StallM to freeze the pipeline while the CPU waits for the port or for read data.

Parameters:
- ADDR_W, 18, word address width.
- DATA_W, 32, data word width.
- CAM_BURST, 4, maximum consecutive camera beats per grant (>=1).
- CAM_MAX_WAIT, 8, cycles a pending camera request may lose before it is forced a grant (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- MemReadM  in  1  CPU read request (LOAD)
- MemWriteM  in  1  CPU write request (STR/STR_ONE); MemReadM and MemWriteM are never both high
- ALUResultM  in  ADDR_W  CPU word address
- WriteDataM  in  DATA_W  CPU store data
- ReadDataM  out  DATA_W  CPU read data, registered
- StallM  out  1  pipeline freeze; combinational from state and requests
- cam_valid  in  1  camera word available
- cam_addr  in  ADDR_W  camera word address
- cam_data  in  DATA_W  camera word
- cam_ready  out  1  camera beat accepted this cycle
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after read issue

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; cam_wait_cnt = 0; burst_cnt = 0; ReadDataM = 0.
  - All outputs 0: StallM = 0, cam_ready = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- States: IDLE, CPU_RD, CAM.
- IDLE, CPU requesting and cam_wait_cnt < CAM_MAX_WAIT: the CPU wins.
  - Write: mem_en = 1, mem_we = 1, address and data from the CPU; completes this cycle; StallM = 0.
  - Read: mem_en = 1, mem_we = 0, StallM = 1; next state CPU_RD.
  - A pending camera request (cam_valid = 1) is held off with cam_ready = 0, and cam_wait_cnt increments.
- IDLE, cam_valid = 1 and (no CPU request, or cam_wait_cnt == CAM_MAX_WAIT): the camera wins.
  - cam_ready = 1; memory write from cam_addr/cam_data; burst_cnt = 1; cam_wait_cnt = 0.
  - Next state CAM if CAM_BURST > 1, else IDLE.
  - StallM = 1 if the CPU is requesting.
- CPU_RD: ReadDataM <= mem_rdata at the end of this cycle; StallM = 0; mem_en = 0; next state IDLE. Total CPU read latency is 2 cycles, with 1 stall cycle.
- CAM:
  - While cam_valid = 1 and burst_cnt < CAM_BURST: accept a beat, write memory, increment burst_cnt, StallM = CPU request.
  - Exit to IDLE in the same cycle that cam_valid = 0; no beat is accepted in that cycle.
  - Exit to IDLE after the beat that brings burst_cnt to CAM_BURST; burst_cnt is cleared on exit.
  - After an exit, a CPU request pending in IDLE wins the next cycle (cam_wait_cnt == 0).
- cam_wait_cnt:
  - Saturates at CAM_MAX_WAIT.
  - Clears on every camera grant.
  - Clears when cam_valid is low in IDLE.
- Handshake: the camera holds cam_addr/cam_data stable while cam_valid && !cam_ready. A transfer happens only when cam_valid && cam_ready.
- CPU signals are held stable by the pipeline while StallM = 1.
- Simultaneous first-cycle requests: the CPU wins unless starvation is reached.
- Reset mid-read: the pending read is dropped and ReadDataM = 0.
- Reset mid-burst: the beat in flight is not acknowledged after reset.
- Widths: burst_cnt is $clog2(CAM_BURST+1) bits; cam_wait_cnt is $clog2(CAM_MAX_WAIT+1) bits. No arithmetic on data.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum arb_state_t {IDLE, CPU_RD, CAM}.
  - Default widths ADDR_W_DEF / DATA_W_DEF.
- One natural sub-module, arb_sat_counter: saturating up-counter with clear, parameterized by max value. Instantiated twice, once for cam_wait_cnt and once for burst_cnt.

Test Plan:
- Reset state: assert rst_n=0 mid-cycle -> all outputs 0 immediately; ReadDataM=0.
- CPU read, camera idle: MemReadM=1, addr 0x00010, mem holds 0xDEADBEEF -> StallM=1 in cycle 0, ReadDataM=0xDEADBEEF and StallM=0 in cycle 1; no camera activity.
- CPU write concurrent with camera: CPU store 0x12345678 to 0x00020 with cam_valid=1 -> write in 1 cycle, StallM=0, cam_ready=0; camera beat accepted the next cycle.
- Camera burst, CAM_BURST=4: 6 back-to-back valid beats, CPU read pending from beat 2 -> beats 1-4 accepted consecutively with StallM=1; CPU read issued in cycle 5; beats 5-6 accepted after CPU_RD.
- Starvation, CAM_MAX_WAIT=8: continuous CPU stores with cam_valid=1 -> camera forced a grant on cycle 9; CPU stalled exactly that cycle.
- Camera valid drop: cam_valid goes low after 2 beats of a burst -> return to IDLE; burst_cnt=0; a new burst then allows 4 beats.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter between
// the CPU MEM stage and the camera pixel writer.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 18;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      CAM    = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear. When clear and increment
// are both asserted, the counter restarts from zero and counts once.
module arb_sat_counter
   import mem_arb_pkg::*;
#(
   parameter int MAX_VAL = 4,
   parameter int CNT_W   = $clog2(MAX_VAL + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] base_s;

   // next count: optional clear, then increment unless already saturated
   always_comb begin
      base_s = clr_i ? '0 : cnt_q;
      if (inc_i && (base_s < CNT_W'(MAX_VAL))) begin
         cnt_d = base_s + CNT_W'(1);
      end else begin
         cnt_d = base_s;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and the
// camera writer, stalling the pipeline while the CPU waits.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int CAM_BURST    = 4,
   parameter int CAM_MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [DATA_W-1:0] WriteDataM,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              StallM,
   input  logic              cam_valid,
   input  logic [ADDR_W-1:0] cam_addr,
   input  logic [DATA_W-1:0] cam_data,
   output logic              cam_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int BURST_W = $clog2(CAM_BURST + 1);
   localparam int WAIT_W  = $clog2(CAM_MAX_WAIT + 1);

   arb_state_t        state_q, state_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic [BURST_W-1:0] burst_cnt_s;
   logic [WAIT_W-1:0]  wait_cnt_s;
   logic burst_clr_s, burst_inc_s, wait_clr_s, wait_inc_s;
   logic cpu_req_s, cam_forced_s, last_beat_s;
   logic stall_s, ready_s, en_s, we_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] wdata_s;

   assign cpu_req_s    = MemReadM | MemWriteM;
   assign cam_forced_s = cam_valid && (wait_cnt_s == WAIT_W'(CAM_MAX_WAIT));
   // burst_cnt is zero in IDLE, so this also marks a grant that is the last beat
   assign last_beat_s  = (burst_cnt_s == BURST_W'(CAM_BURST - 1));

   // next state, port muxing and counter controls
   always_comb begin
      state_d     = state_q;
      read_data_d = read_data_q;
      stall_s     = 1'b0;
      ready_s     = 1'b0;
      en_s        = 1'b0;
      we_s        = 1'b0;
      addr_s      = '0;
      wdata_s     = '0;
      burst_clr_s = 1'b0;
      burst_inc_s = 1'b0;
      wait_clr_s  = 1'b0;
      wait_inc_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req_s && !cam_forced_s) begin
               en_s    = 1'b1;
               we_s    = MemWriteM;
               addr_s  = ALUResultM;
               wdata_s = WriteDataM;
               if (MemReadM) begin
                  stall_s = 1'b1;
                  state_d = CPU_RD;
               end else begin
                  state_d = IDLE;
               end
               if (cam_valid) begin
                  wait_inc_s = 1'b1;
               end else begin
                  wait_clr_s = 1'b1;
               end
            end else if (cam_valid) begin
               ready_s    = 1'b1;
               en_s       = 1'b1;
               we_s       = 1'b1;
               addr_s     = cam_addr;
               wdata_s    = cam_data;
               stall_s    = cpu_req_s;
               wait_clr_s = 1'b1;
               if (last_beat_s) begin
                  burst_clr_s = 1'b1;
                  state_d     = IDLE;
               end else begin
                  burst_inc_s = 1'b1;
                  state_d     = CAM;
               end
            end else begin
               wait_clr_s = 1'b1;
            end
         end
         CPU_RD: begin
            read_data_d = mem_rdata;
            state_d     = IDLE;
         end
         CAM: begin
            stall_s = cpu_req_s;
            if (cam_valid) begin
               ready_s = 1'b1;
               en_s    = 1'b1;
               we_s    = 1'b1;
               addr_s  = cam_addr;
               wdata_s = cam_data;
               if (last_beat_s) begin
                  burst_clr_s = 1'b1;
                  state_d     = IDLE;
               end else begin
                  burst_inc_s = 1'b1;
                  state_d     = CAM;
               end
            end else begin
               burst_clr_s = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and read-data registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         read_data_q <= read_data_d;
      end
   end

   arb_sat_counter #(
      .MAX_VAL (CAM_MAX_WAIT),
      .CNT_W   (WAIT_W)
   ) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (wait_clr_s),
      .inc_i (wait_inc_s),
      .cnt_o (wait_cnt_s)
   );

   arb_sat_counter #(
      .MAX_VAL (CAM_BURST),
      .CNT_W   (BURST_W)
   ) u_burst_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (burst_clr_s),
      .inc_i (burst_inc_s),
      .cnt_o (burst_cnt_s)
   );

   // outputs are forced low while reset is held so no beat is acknowledged
   assign StallM    = rst_n & stall_s;
   assign cam_ready = rst_n & ready_s;
   assign mem_en    = rst_n & en_s;
   assign mem_we    = rst_n & we_s;
   assign mem_addr  = rst_n ? addr_s : '0;
   assign mem_wdata = rst_n ? wdata_s : '0;
   assign ReadDataM = read_data_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus random
// traffic, all checked against a cycle-level behavioural model.
module tb_data_mem_arbiter;

   localparam int AW    = 18;
   localparam int DW    = 32;
   localparam int BURST = 4;
   localparam int MAXW  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          MemReadM, MemWriteM;
   logic [AW-1:0] ALUResultM;
   logic [DW-1:0] WriteDataM;
   logic [DW-1:0] ReadDataM;
   logic          StallM;
   logic          cam_valid;
   logic [AW-1:0] cam_addr;
   logic [DW-1:0] cam_data;
   logic          cam_ready;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always #5 clk = ~clk;

   data_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .CAM_BURST(BURST), .CAM_MAX_WAIT(MAXW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .StallM(StallM),
      .cam_valid(cam_valid), .cam_addr(cam_addr), .cam_data(cam_data),
      .cam_ready(cam_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // 64-word synchronous memory with a preload port
   logic [DW-1:0] mem [64];
   logic          pl_we;
   logic [5:0]    pl_a;
   logic [DW-1:0] pl_d;

   always @(posedge clk) begin
      if (pl_we) mem[pl_a] <= pl_d;
      else if (mem_en && mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[5:0]];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // behavioural model state
   logic [DW-1:0] shadow [64];
   bit            m_rd_phase, m_burst;
   int            m_beats, m_wait;
   logic [DW-1:0] m_rd_val, exp_rd;
   bit            exp_en, exp_we, exp_stall, exp_ready;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wd;

   task automatic model_reset();
      m_rd_phase = 1'b0; m_burst = 1'b0; m_beats = 0; m_wait = 0;
      exp_rd = '0;
   endtask

   task automatic cam_beat();
      exp_ready = 1'b1; exp_en = 1'b1; exp_we = 1'b1;
      exp_addr = cam_addr; exp_wd = cam_data;
      shadow[cam_addr[5:0]] = cam_data;
   endtask

   // one cycle of the reference: predict outputs from the rules, then compare
   task automatic model_step();
      bit            cpu_req;
      logic [DW-1:0] nxt_rd;
      exp_en = 1'b0; exp_we = 1'b0; exp_stall = 1'b0; exp_ready = 1'b0;
      exp_addr = '0; exp_wd = '0;
      if (!rst_n) begin
         model_reset();
         check_eq("rst_rdata", 64'(ReadDataM), 64'(0));
         check_eq("rst_stall", 64'(StallM), 64'(0));
         check_eq("rst_ready", 64'(cam_ready), 64'(0));
         check_eq("rst_en", 64'(mem_en), 64'(0));
         check_eq("rst_we", 64'(mem_we), 64'(0));
         check_eq("rst_addr", 64'(mem_addr), 64'(0));
         check_eq("rst_wdata", 64'(mem_wdata), 64'(0));
         return;
      end
      check_eq("rdata", 64'(ReadDataM), 64'(exp_rd));
      nxt_rd  = exp_rd;
      cpu_req = MemReadM || MemWriteM;
      if (m_rd_phase) begin
         m_rd_phase = 1'b0;
         nxt_rd     = m_rd_val;
      end else if (m_burst) begin
         exp_stall = cpu_req;
         if (cam_valid) begin
            cam_beat();
            m_beats++;
            if (m_beats >= BURST) m_burst = 1'b0;
         end else begin
            m_burst = 1'b0;
         end
      end else if (cpu_req && !(cam_valid && m_wait >= MAXW)) begin
         exp_en = 1'b1; exp_addr = ALUResultM;
         if (MemWriteM) begin
            exp_we = 1'b1; exp_wd = WriteDataM;
            shadow[ALUResultM[5:0]] = WriteDataM;
         end else begin
            exp_stall  = 1'b1;
            m_rd_phase = 1'b1;
            m_rd_val   = shadow[ALUResultM[5:0]];
         end
         m_wait = cam_valid ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : 0;
      end else if (cam_valid) begin
         cam_beat();
         exp_stall = cpu_req;
         m_beats   = 1;
         m_burst   = (BURST > 1);
         m_wait    = 0;
      end else begin
         m_wait = 0;
      end
      check_eq("stall", 64'(StallM), 64'(exp_stall));
      check_eq("ready", 64'(cam_ready), 64'(exp_ready));
      check_eq("en", 64'(mem_en), 64'(exp_en));
      if (exp_en) begin
         check_eq("we", 64'(mem_we), 64'(exp_we));
         check_eq("addr", 64'(mem_addr), 64'(exp_addr));
         if (exp_we) check_eq("wdata", 64'(mem_wdata), 64'(exp_wd));
      end
      exp_rd = nxt_rd;
   endtask

   // from posedge+1: model at the falling edge, then on to the next posedge+1
   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_cam_word();
      cam_addr = AW'(40 + $urandom_range(0, 23));
      cam_data = $urandom;
   endtask

   // cycle table: bit c of each vector describes cycle c
   task automatic run_table(input string tag, input int n,
                            input logic [15:0] vld, input logic [15:0] cpu,
                            input logic [15:0] rdy, input logic [15:0] stl,
                            input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit adv;
      adv = 1'b1;
      ALUResultM = a; WriteDataM = d;
      for (int c = 0; c < n; c++) begin
         if (adv) new_cam_word();
         cam_valid = vld[c];
         MemReadM  = cpu[c] & ~wr;
         MemWriteM = cpu[c] & wr;
         #1;
         check_eq($sformatf("%s_ready_c%0d", tag, c), 64'(cam_ready), 64'(rdy[c]));
         check_eq($sformatf("%s_stall_c%0d", tag, c), 64'(StallM), 64'(stl[c]));
         adv = cam_ready;
         tick();
      end
      cam_valid = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int grant_c, stall_at_grant, stalls_before;
      rst_n = 1'b0;
      MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
      cam_valid = 1'b1; cam_addr = '0; cam_data = '0;
      pl_we = 1'b0; pl_a = '0; pl_d = '0;
      model_reset();
      #1;
      // requests are active during reset: outputs must stay low while memory is preloaded
      for (int i = 0; i < 64; i++) begin
         pl_we = 1'b1; pl_a = 6'(i);
         pl_d = (i == 16) ? 32'hDEAD_BEEF : $urandom;
         shadow[i] = pl_d;
         tick();
      end
      pl_we = 1'b0; MemReadM = 1'b0; cam_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      run_table("cpu_rd", 2, 16'h0000, 16'h0003, 16'h0000, 16'h0001, 1'b0, AW'(16), 32'h0);
      check_eq("cpu_rd_data", 64'(ReadDataM), 64'(32'hDEAD_BEEF));
      run_table("wr_vs_cam", 2, 16'h0003, 16'h0001, 16'h0002, 16'h0000, 1'b1, AW'(32), 32'h1234_5678);
      run_table("burst_rd", 8, 16'h00FF, 16'h003E, 16'h00CF, 16'h001E, 1'b0, AW'(36), 32'h0);

      grant_c = 0; stall_at_grant = 0; stalls_before = 0;
      cam_valid = 1'b1; new_cam_word();
      MemWriteM = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         if (c == 1 || !exp_stall) begin
            ALUResultM = AW'(48 + (c % 8)); WriteDataM = $urandom;
         end
         if (grant_c != 0) cam_valid = 1'b0;
         #1;
         if (cam_ready && grant_c == 0) begin
            grant_c = c; stall_at_grant = int'(StallM);
         end else if (grant_c == 0 && StallM) begin
            stalls_before++;
         end
         tick();
      end
      MemWriteM = 1'b0;
      tick();
      tick();
      check_eq("starve_grant_cycle", 64'(grant_c), 64'(9));
      check_eq("starve_stall_at_grant", 64'(stall_at_grant), 64'(1));
      check_eq("starve_early_stalls", 64'(stalls_before), 64'(0));

      run_table("vld_drop", 9, 16'h01FB, 16'h00F0, 16'h017B, 16'h0070, 1'b1, AW'(8), 32'hA5A5_0F0F);

      // reset while a read is in its data cycle
      MemReadM = 1'b1; ALUResultM = AW'(16); cam_valid = 1'b1; new_cam_word();
      tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("midrd_rdata", 64'(ReadDataM), 64'(0));
      check_eq("midrd_stall", 64'(StallM), 64'(0));
      check_eq("midrd_ready", 64'(cam_ready), 64'(0));
      check_eq("midrd_en", 64'(mem_en), 64'(0));
      tick();
      rst_n = 1'b1; MemReadM = 1'b0; cam_valid = 1'b0;
      tick();
      check_eq("midrd_dropped", 64'(ReadDataM), 64'(0));

      // reset in the middle of a camera burst
      cam_valid = 1'b1; new_cam_word();
      tick();
      new_cam_word();
      tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("midburst_ready", 64'(cam_ready), 64'(0));
      check_eq("midburst_we", 64'(mem_we), 64'(0));
      tick();
      rst_n = 1'b1; cam_valid = 1'b0;
      tick();

      // random traffic honouring both handshakes
      for (int i = 0; i < 4000; i++) begin
         int r;
         int pct;
         if (!((MemReadM || MemWriteM) && exp_stall)) begin
            r = $urandom_range(0, 7);
            MemReadM   = (r == 3 || r == 4);
            MemWriteM  = (r >= 5);
            ALUResultM = AW'($urandom_range(0, 63));
            WriteDataM = $urandom;
         end
         if (!(cam_valid && !exp_ready)) begin
            pct = ((i / 500) % 2 == 1) ? 90 : 40;
            cam_valid = ($urandom_range(0, 99) < pct);
            new_cam_word();
         end
         tick();
      end
      MemReadM = 1'b0; MemWriteM = 1'b0; cam_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      for (int i = 0; i < 64; i++) begin
         check_eq($sformatf("mem_word_%0d", i), 64'(mem[i]), 64'(shadow[i]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
